quad_xor_tester: RTL and testbench
==================================

// Module: quad_xor_tester
// PURPOSE
//   On-board self-test engine for a quad 2-input XOR gate (74HC86-class part or its RTL model).
//   Drives each gate's two inputs through the full truth table, samples the gate outputs
//   after a settle interval, and reports per-gate pass/fail.
//   Sits between the board pin muxing and the user LEDs/switches of the lab top level.
// PARAMETERS
//   SETTLE_CYCLES  4  clk cycles waited after driving a vector before sampling; legal range 3..255
// PORTS
//   clk        in   1  system clock; all logic on rising edge
//   rst        in   1  synchronous, active-high reset
//   start      in   1  request a test run; sampled only in IDLE
//   a_out      out  4  first input of gates 0..3 (a1,b1,c1,d1 order)
//   b_out      out  4  second input of gates 0..3 (a2,b2,c2,d2 order)
//   y_in       in   4  gate outputs y1..y4; asynchronous to clk
//   busy       out  1  high from start acceptance until done
//   done       out  1  one-cycle pulse when a run completes
//   pass       out  1  1 = last run had no mismatches; held until next start accepted
//   fail_mask  out  4  bit i = gate i mismatched on at least one vector; held until next start
//   vec_idx    out  2  vector currently applied (debug)
// BEHAVIOUR
//   - Reset: a_out=0, b_out=0, busy=0, done=0, pass=0, fail_mask=0, vec_idx=0, state IDLE.
//     Reset mid-run aborts immediately; no done pulse; results cleared.
//   - y_in passes through a 2-flop synchronizer before use (2-cycle latency, hence SETTLE_CYCLES>=3).
//   - FSM: IDLE -> DRIVE -> SETTLE -> SAMPLE -> (DRIVE | DONE) -> IDLE.
//     IDLE: start=1 -> busy=1, fail_mask=0, pass=0, vec_idx=0, go DRIVE. start=0 -> stay.
//     DRIVE (1 cycle): register a_out/b_out for vector k; settle counter loaded.
//     SETTLE (SETTLE_CYCLES cycles): outputs held; counter decrements to 0.
//     SAMPLE (1 cycle): fail_mask |= sync_y ^ expected; k==3 -> DONE else k+1, DRIVE.
//     DONE (1 cycle): done=1, busy=0, pass=(fail_mask==0), a_out=b_out=0; go IDLE.
//   - Vector k (2 bits): gate input a = k[1], b = k[0]; expected y = k[1]^k[0].
//     Order k=0,1,2,3 -> (0,0),(0,1),(1,0),(1,1) -> expected 0,1,1,0.
//   - Latency: start accepted at edge T -> done high in cycle T + 4*(SETTLE_CYCLES+2) + 1.
//   - start while busy (any non-IDLE state) ignored; start held high re-triggers only after DONE.
//   - start and rst together: rst wins.
// CONFIGURATION
//   XOR_TESTER_STAGGER_EN
//     defined:   gate i receives vector (k+i) mod 4 in step k, so adjacent gates never carry
//                identical expected outputs on every step; detects output bridging between gates.
//                Expected value computed per gate from its own rotated vector.
//     undefined: all four gates receive vector k simultaneously; a_out/b_out bits all equal.
//     Timing, FSM and port list identical in both builds.
// STRUCTURE
//   - Package xor_tester_pkg: state enum (IDLE,DRIVE,SETTLE,SAMPLE,DONE), vector width
//     constant, function expected_y(vec) and rotate helper, SETTLE_CYCLES legal-range constants.
//   - Sub-module sync_2ff (4-bit wide, reset to 0) for y_in.
//   - Remaining logic (FSM, settle counter, vector counter, compare/accumulate) in this module.
// TESTING
//   1. Ideal XOR model on a_out/b_out->y_in, SETTLE_CYCLES=4, start pulse -> done after 25
//      cycles, pass=1, fail_mask=4'b0000, busy high throughout.
//   2. Gate 2 output stuck at 0 -> fail_mask=4'b0100, pass=0 (fails vectors 1 and 2).
//   3. Model replaced with AND on all gates -> fail_mask=4'b1111, pass=0.
//   4. start pulsed again during SETTLE of vector 1 -> ignored; exactly one done pulse, result as 1.
//   5. rst asserted in SETTLE of vector 2 -> next cycle busy=0, a_out=b_out=0, fail_mask=0,
//      no done; new start then yields pass=1.
//   6. XOR_TESTER_STAGGER_EN defined, y2 shorted to y1 -> fail_mask=4'b0010, pass=0;
//      same short without the macro -> pass=1 (documented coverage gap).

Source files
------------

// File: rtl/xor_tester_pkg.sv
// Shared types and helpers for the quad XOR gate self-tester.
package xor_tester_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRIVE  = 3'd1,
    SETTLE = 3'd2,
    SAMPLE = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam int VEC_W      = 2;
  localparam int SETTLE_MIN = 3;
  localparam int SETTLE_MAX = 255;

  function automatic logic expected_y(input logic [VEC_W-1:0] vec);
    return vec[1] ^ vec[0];
  endfunction

  // Vector index applied to gate i on step k when gates are staggered.
  function automatic logic [VEC_W-1:0] rotate(input logic [VEC_W-1:0] k, input int i);
    return k + VEC_W'(i);
  endfunction

endpackage

// File: rtl/quad_xor_tester_sync_2ff.sv
// Two-flop synchronizer for the asynchronous gate outputs; resets to zero.
module sync_2ff #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_r;

  // Two-stage capture of d into the clk domain.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_r <= '0;
      q      <= '0;
    end else begin
      meta_r <= d;
      q      <= meta_r;
    end
  end

endmodule

// File: rtl/quad_xor_tester.sv
// Self-test engine for a quad 2-input XOR gate: walks the truth table, reports per-gate result.
// Build option XOR_TESTER_STAGGER_EN rotates the vector per gate to expose output bridging.
module quad_xor_tester
  import xor_tester_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [3:0] a_out,
  output logic [3:0] b_out,
  input  logic [3:0] y_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_mask,
  output logic [1:0] vec_idx
);

  localparam int SETTLE_EFF = (SETTLE_CYCLES < SETTLE_MIN) ? SETTLE_MIN :
                              (SETTLE_CYCLES > SETTLE_MAX) ? SETTLE_MAX : SETTLE_CYCLES;
  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_EFF - 1);

  state_t     state_r;
  logic [7:0] cnt_r;
  logic [3:0] sync_y_s;
  logic [3:0] vec_a_s;
  logic [3:0] vec_b_s;
  logic [3:0] exp_y_s;
  logic [1:0] gate_vec_s;

  sync_2ff #(.WIDTH(4)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (y_in),
    .q   (sync_y_s)
  );

  // Per-gate stimulus and expected output for the current step.
  always_comb begin
    vec_a_s    = 4'b0000;
    vec_b_s    = 4'b0000;
    exp_y_s    = 4'b0000;
    gate_vec_s = 2'b00;
    for (int i = 0; i < 4; i++) begin
`ifdef XOR_TESTER_STAGGER_EN
      gate_vec_s = rotate(vec_idx, i);
`else
      gate_vec_s = vec_idx;
`endif
      vec_a_s[i] = gate_vec_s[1];
      vec_b_s[i] = gate_vec_s[0];
      exp_y_s[i] = expected_y(gate_vec_s);
    end
  end

  // Test sequencer with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      cnt_r     <= 8'd0;
      a_out     <= 4'b0000;
      b_out     <= 4'b0000;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_mask <= 4'b0000;
      vec_idx   <= 2'd0;
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            busy      <= 1'b1;
            fail_mask <= 4'b0000;
            pass      <= 1'b0;
            vec_idx   <= 2'd0;
            state_r   <= DRIVE;
          end else begin
            state_r   <= IDLE;
          end
        end
        DRIVE: begin
          a_out   <= vec_a_s;
          b_out   <= vec_b_s;
          cnt_r   <= SETTLE_LOAD;
          state_r <= SETTLE;
        end
        SETTLE: begin
          if (cnt_r == 8'd0) begin
            state_r <= SAMPLE;
          end else begin
            cnt_r   <= cnt_r - 8'd1;
          end
        end
        SAMPLE: begin
          fail_mask <= fail_mask | (sync_y_s ^ exp_y_s);
          if (vec_idx == 2'd3) begin
            state_r <= DONE;
          end else begin
            vec_idx <= vec_idx + 2'd1;
            state_r <= DRIVE;
          end
        end
        DONE: begin
          done    <= 1'b1;
          busy    <= 1'b0;
          pass    <= (fail_mask == 4'b0000);
          a_out   <= 4'b0000;
          b_out   <= 4'b0000;
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_quad_xor_tester.sv
// Scoreboard bench for quad_xor_tester with a switchable gate fault model on y_in.
module tb_quad_xor_tester;

  localparam int S       = 4;
  localparam int STEP    = S + 2;
  localparam int RUN_LAT = 4 * STEP + 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] a_out;
  logic [3:0] b_out;
  logic [3:0] y_in;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] fail_mask;
  logic [1:0] vec_idx;

  int         mode;
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [4:0] sb_q[$];
  logic [3:0] xor_s;

  always #5 clk = ~clk;

  quad_xor_tester #(.SETTLE_CYCLES(S)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a_out     (a_out),
    .b_out     (b_out),
    .y_in      (y_in),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .fail_mask (fail_mask),
    .vec_idx   (vec_idx)
  );

  // Gate model: 0 ideal XOR, 1 gate 2 stuck at 0, 2 AND gates, 3 y2 shorted to y1.
  always_comb begin
    xor_s = a_out ^ b_out;
    y_in  = xor_s;
    case (mode)
      1: y_in[2] = 1'b0;
      2: y_in = a_out & b_out;
      3: y_in[1] = xor_s[0];
      default: y_in = xor_s;
    endcase
  end

  function automatic int gate_vec(input int k, input int g);
`ifdef XOR_TESTER_STAGGER_EN
    return (k + g) % 4;
`else
    return k;
`endif
  endfunction

  // Expected {pass, fail_mask} for a run under fault mode m.
  function automatic logic [4:0] model_result(input int m);
    logic [3:0] mask, ga, gb, y, e;
    mask = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      for (int g = 0; g < 4; g++) begin
        ga[g] = gate_vec(k, g) / 2;
        gb[g] = gate_vec(k, g) % 2;
      end
      e = ga ^ gb;
      y = e;
      if (m == 1) y[2] = 1'b0;
      if (m == 2) y = ga & gb;
      if (m == 3) y[1] = e[0];
      mask = mask | (y ^ e);
    end
    return {(mask == 4'b0000), mask};
  endfunction

  // Expected {vec_idx, a_out, b_out} per step, 10 bits each.
  function automatic logic [39:0] model_snap();
    logic [39:0] s;
    logic [3:0]  ga, gb;
    logic [1:0]  kk;
    s = 40'd0;
    for (int k = 0; k < 4; k++) begin
      for (int g = 0; g < 4; g++) begin
        ga[g] = gate_vec(k, g) / 2;
        gb[g] = gate_vec(k, g) % 2;
      end
      kk = 2'(k);
      s[k*10 +: 10] = {kk, ga, gb};
    end
    return s;
  endfunction

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  // Runs until done (bounded); cycles = -1 on timeout. Optional start re-pulse at cycle repulse_at.
  task automatic wait_done(input int repulse_at, output int cycles, output int busy_errs,
                           output logic [39:0] snap);
    cycles    = -1;
    busy_errs = 0;
    snap      = 40'd0;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (repulse_at >= 0) start = (n == repulse_at);
      if (done) begin
        cycles = n;
        break;
      end
      if (!busy) busy_errs++;
      for (int k = 0; k < 4; k++)
        if (n == k * STEP + 3) snap[k*10 +: 10] = {vec_idx, a_out, b_out};
    end
    if (repulse_at >= 0) start = 1'b0;
  endtask

  task automatic test_reset();
    mode = 0; start = 1'b0; rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if ({a_out, b_out} !== 8'h00) begin
      n_bad++; $display("FAIL reset_ab: got %h want 00", {a_out, b_out});
    end
    n_cmp++;
    if ({busy, done, pass} !== 3'b000) begin
      n_bad++; $display("FAIL reset_flags: got %b want 000", {busy, done, pass});
    end
    n_cmp++;
    if ({fail_mask, vec_idx} !== 6'd0) begin
      n_bad++; $display("FAIL reset_mask_idx: got %b want 000000", {fail_mask, vec_idx});
    end
  endtask

  task automatic test_ideal();
    int cyc, berr; logic [39:0] snap; logic [4:0] exp;
    mode = 0;
    sb_q.push_back(model_result(0));
    pulse_start();
    wait_done(-1, cyc, berr, snap);
    n_cmp++;
    if (cyc !== RUN_LAT) begin n_bad++; $display("FAIL ideal_latency: got %0d want %0d", cyc, RUN_LAT); end
    n_cmp++;
    if (berr !== 0) begin n_bad++; $display("FAIL ideal_busy: low in %0d run cycles, want 0", berr); end
    n_cmp++;
    if ({busy, a_out, b_out} !== 9'd0) begin
      n_bad++; $display("FAIL ideal_end_state: busy/a/b got %b want 0", {busy, a_out, b_out});
    end
    n_cmp++;
    if (snap !== model_snap()) begin
      n_bad++; $display("FAIL ideal_vectors: got %h want %h", snap, model_snap());
    end
    exp = sb_q.pop_front();
    n_cmp++;
    if ({pass, fail_mask} !== exp) begin
      n_bad++; $display("FAIL ideal_result: got %b want %b", {pass, fail_mask}, exp);
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0) begin n_bad++; $display("FAIL ideal_done_width: got %b want 0", done); end
  endtask

  task automatic test_fault_modes();
    int cyc, berr; logic [39:0] snap; logic [4:0] exp;
    for (int m = 1; m <= 3; m++) begin
      mode = m;
      sb_q.push_back(model_result(m));
      pulse_start();
      wait_done(-1, cyc, berr, snap);
      n_cmp++;
      if (cyc !== RUN_LAT) begin n_bad++; $display("FAIL fault%0d_latency: got %0d want %0d", m, cyc, RUN_LAT); end
      exp = sb_q.pop_front();
      n_cmp++;
      if ({pass, fail_mask} !== exp) begin
        n_bad++; $display("FAIL fault%0d_result: got %b want %b", m, {pass, fail_mask}, exp);
      end
      @(negedge clk);
    end
    mode = 0;
  endtask

  task automatic test_start_ignored();
    int cyc, berr, extra; logic [39:0] snap; logic [4:0] exp;
    mode = 0;
    sb_q.push_back(model_result(0));
    pulse_start();
    wait_done(STEP + 2, cyc, berr, snap);
    n_cmp++;
    if (cyc !== RUN_LAT) begin n_bad++; $display("FAIL ignore_latency: got %0d want %0d", cyc, RUN_LAT); end
    exp = sb_q.pop_front();
    n_cmp++;
    if ({pass, fail_mask} !== exp) begin
      n_bad++; $display("FAIL ignore_result: got %b want %b", {pass, fail_mask}, exp);
    end
    extra = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    n_cmp++;
    if (extra !== 0) begin n_bad++; $display("FAIL ignore_second_run: got %0d active cycles want 0", extra); end
  endtask

  task automatic test_reset_mid_run();
    int cyc, berr, extra; logic [39:0] snap; logic [4:0] exp;
    mode = 2;
    pulse_start();
    repeat (2 * STEP + 2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if ({busy, done, a_out, b_out, fail_mask} !== 14'd0) begin
      n_bad++; $display("FAIL midreset_state: got %b want 0", {busy, done, a_out, b_out, fail_mask});
    end
    extra = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    n_cmp++;
    if (extra !== 0) begin n_bad++; $display("FAIL midreset_activity: got %0d want 0", extra); end
    mode = 0;
    sb_q.push_back(model_result(0));
    pulse_start();
    wait_done(-1, cyc, berr, snap);
    exp = sb_q.pop_front();
    n_cmp++;
    if ({pass, fail_mask} !== exp || cyc !== RUN_LAT) begin
      n_bad++; $display("FAIL midreset_rerun: got %b cyc %0d want %b cyc %0d", {pass, fail_mask}, cyc, exp, RUN_LAT);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int cyc, berr; logic [39:0] snap; logic [4:0] exp;
    mode = 0;
    sb_q.push_back(model_result(0));
    sb_q.push_back(model_result(0));
    @(negedge clk) start = 1'b1;
    @(negedge clk);
    wait_done(-1, cyc, berr, snap);
    n_cmp++;
    if (cyc !== RUN_LAT) begin n_bad++; $display("FAIL b2b_first_latency: got %0d want %0d", cyc, RUN_LAT); end
    exp = sb_q.pop_front();
    n_cmp++;
    if ({pass, fail_mask} !== exp) begin
      n_bad++; $display("FAIL b2b_first_result: got %b want %b", {pass, fail_mask}, exp);
    end
    @(negedge clk);
    start = 1'b0;
    n_cmp++;
    if ({busy, done, pass} !== 3'b100) begin
      n_bad++; $display("FAIL b2b_retrigger: busy/done/pass got %b want 100", {busy, done, pass});
    end
    wait_done(-1, cyc, berr, snap);
    exp = sb_q.pop_front();
    n_cmp++;
    if ({pass, fail_mask} !== exp || cyc !== RUN_LAT) begin
      n_bad++; $display("FAIL b2b_second: got %b cyc %0d want %b cyc %0d", {pass, fail_mask}, cyc, exp, RUN_LAT);
    end
    @(negedge clk);
  endtask

  initial begin
    mode  = 0;
    rst   = 1'b1;
    start = 1'b0;
    test_reset();
    test_ideal();
    test_fault_modes();
    test_start_ignored();
    test_reset_mid_run();
    test_back_to_back();
    n_cmp++;
    if (sb_q.size() !== 0) begin n_bad++; $display("FAIL scoreboard_drain: got %0d entries want 0", sb_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
